// File: rtl/ram_bank_handoff_ctrl_pkg.sv
// Shared types and register map for the A-line RAM bank ping-pong handoff.
package ram_bank_handoff_ctrl_pkg;

   typedef enum logic [1:0] {
      BANK_FREE    = 2'd0,
      BANK_FILLING = 2'd1,
      BANK_READY   = 2'd2,
      BANK_READING = 2'd3
   } bank_state_e;

   typedef enum logic {
      WR_IDLE = 1'b0,
      WR_FILL = 1'b1
   } wr_state_e;

   localparam logic [1:0] REG_CTRL   = 2'd0;
   localparam logic [1:0] REG_STATUS = 2'd1;
   localparam logic [1:0] REG_ERR    = 2'd2;
   localparam logic [1:0] REG_IRQEN  = 2'd3;

   localparam int CTRL_CLAIM_BIT     = 0;
   localparam int CTRL_RD_BANK_BIT   = 0;
   localparam int CTRL_READING_BIT   = 1;
   localparam int CTRL_READY_ANY_BIT = 2;

   localparam int STATUS_FSM_BIT     = 0;
   localparam int STATUS_WR_BANK_BIT = 1;
   localparam int STATUS_BANK0_LSB   = 4;
   localparam int STATUS_BANK1_LSB   = 6;

endpackage

// File: rtl/ram_bank_handoff_ctrl_if.sv
// Avalon-MM host register port plus the host interrupt line.
interface ram_bank_handoff_ctrl_if;
   logic [1:0]  address;
   logic        chipselect;
   logic        write_n;
   logic [31:0] writedata;
   logic [31:0] readdata;
   logic        irq;

   modport master (output address, chipselect, write_n, writedata, input readdata, irq);
   modport slave  (input address, chipselect, write_n, writedata, output readdata, irq);
endinterface

// File: rtl/ram_bank_handoff_ctrl_line_writer.sv
// Acquisition-side writer: claims a free bank on sweep start and walks the line address.
//  state   | meaning
//  WR_IDLE | waiting for acq_sof (or a sof deferred from the last line's final sample)
//  WR_FILL | writing samples into wr_bank, wr_addr advances per accepted acq_valid
module ram_line_writer
   import ram_bank_handoff_ctrl_pkg::*;
#(
   parameter int ADDR_W   = 12,
   parameter int LINE_LEN = 1024
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              acq_sof,
   input  logic              acq_valid,
   input  logic              free_avail,
   input  logic              free_idx,
   output logic              wr_en,
   output logic [ADDR_W-1:0] wr_addr,
   output logic              wr_bank,
   output wr_state_e         fsm,
   output logic              fill_start,
   output logic              fill_done,
   output logic              fill_abort,
   output logic              sof_drop
);

   localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(LINE_LEN - 1);

   wr_state_e         state_q, state_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic              bank_q, bank_d;
   logic              pend_q, pend_d;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= WR_IDLE;
         addr_q  <= '0;
         bank_q  <= 1'b0;
         pend_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         addr_q  <= addr_d;
         bank_q  <= bank_d;
         pend_q  <= pend_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      addr_d     = addr_q;
      bank_d     = bank_q;
      pend_d     = pend_q;
      wr_en      = 1'b0;
      fill_start = 1'b0;
      fill_done  = 1'b0;
      fill_abort = 1'b0;
      sof_drop   = 1'b0;
      case (state_q)
         WR_IDLE: begin
            pend_d = 1'b0;
            if (acq_sof || pend_q) begin
               if (free_avail) begin
                  bank_d     = free_idx;
                  addr_d     = '0;
                  state_d    = WR_FILL;
                  fill_start = 1'b1;
               end else begin
                  sof_drop = 1'b1;
               end
            end
         end
         WR_FILL: begin
            wr_en = acq_valid;
            if (acq_valid && addr_q == LAST_ADDR) begin
               // line completes; a coincident sof is replayed from IDLE next cycle
               fill_done = 1'b1;
               addr_d    = '0;
               state_d   = WR_IDLE;
               pend_d    = acq_sof;
            end else begin
               if (acq_valid) addr_d = addr_q + 1'b1;
               if (acq_sof) begin
                  fill_abort = 1'b1;
                  addr_d     = '0;
               end
            end
         end
         default: state_d = WR_IDLE;
      endcase
   end

   assign wr_addr = addr_q;
   assign wr_bank = bank_q;
   assign fsm     = state_q;

endmodule

// File: rtl/ram_bank_handoff_ctrl.sv
// Ping-pong ownership of two sample RAM banks between the acquisition writer and the host.
module ram_bank_handoff_ctrl
   import ram_bank_handoff_ctrl_pkg::*;
#(
   parameter int ADDR_W   = 12,
   parameter int LINE_LEN = 1024,
   parameter int CNT_W    = 16
) (
   input  logic                    clk,
   input  logic                    reset_n,
   input  logic                    acq_sof,
   input  logic                    acq_valid,
   output logic                    wr_en,
   output logic [ADDR_W-1:0]       wr_addr,
   output logic                    wr_bank,
   output logic                    rd_bank,
   ram_bank_handoff_ctrl_if.slave  host
);

   localparam logic [CNT_W-1:0] ERR_MAX = {CNT_W{1'b1}};

   bank_state_e      bank_q [2];
   bank_state_e      bank_d [2];
   logic             old_q, old_d;
   logic             rd_bank_q, rd_bank_d;
   logic [CNT_W-1:0] err_q, err_d;
   logic             irq_en_q, irq_en_d;
   logic             irq_q, irq_d;
   logic [31:0]      readdata_q, readdata_d;

   logic      free_avail, free_idx, ready_any, reading, sel;
   logic      fill_start, fill_done, fill_abort, sof_drop;
   logic      host_wr, host_rd, claim, release_req, err_inc;
   wr_state_e fsm;
   logic      unused_wd;

   assign free_avail  = (bank_q[0] == BANK_FREE) || (bank_q[1] == BANK_FREE);
   assign free_idx    = (bank_q[0] != BANK_FREE);
   assign ready_any   = (bank_q[0] == BANK_READY) || (bank_q[1] == BANK_READY);
   assign reading     = (bank_q[0] == BANK_READING) || (bank_q[1] == BANK_READING);
   assign host_wr     = host.chipselect && !host.write_n;
   assign host_rd     = host.chipselect && host.write_n;
   assign claim       = host_wr && host.address == REG_CTRL && host.writedata[CTRL_CLAIM_BIT];
   assign release_req = host_wr && host.address == REG_CTRL && !host.writedata[CTRL_CLAIM_BIT];
   assign err_inc     = sof_drop || fill_abort;
   assign unused_wd   = ^host.writedata[31:1];

   ram_line_writer #(.ADDR_W(ADDR_W), .LINE_LEN(LINE_LEN)) u_writer (
      .clk        (clk),
      .reset_n    (reset_n),
      .acq_sof    (acq_sof),
      .acq_valid  (acq_valid),
      .free_avail (free_avail),
      .free_idx   (free_idx),
      .wr_en      (wr_en),
      .wr_addr    (wr_addr),
      .wr_bank    (wr_bank),
      .fsm        (fsm),
      .fill_start (fill_start),
      .fill_done  (fill_done),
      .fill_abort (fill_abort),
      .sof_drop   (sof_drop)
   );

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         bank_q[0]  <= BANK_FREE;
         bank_q[1]  <= BANK_FREE;
         old_q      <= 1'b0;
         rd_bank_q  <= 1'b0;
         err_q      <= '0;
         irq_en_q   <= 1'b0;
         irq_q      <= 1'b0;
         readdata_q <= '0;
      end else begin
         bank_q[0]  <= bank_d[0];
         bank_q[1]  <= bank_d[1];
         old_q      <= old_d;
         rd_bank_q  <= rd_bank_d;
         err_q      <= err_d;
         irq_en_q   <= irq_en_d;
         irq_q      <= irq_d;
         readdata_q <= readdata_d;
      end
   end

   // Claims act on registered READY state only, so a bank finishing this cycle is not eligible.
   always_comb begin
      bank_d[0] = bank_q[0];
      bank_d[1] = bank_q[1];
      old_d     = old_q;
      rd_bank_d = rd_bank_q;
      sel       = (bank_q[old_q] == BANK_READY) ? old_q : ~old_q;
      if (claim && ready_any && !reading) begin
         bank_d[sel] = BANK_READING;
         rd_bank_d   = sel;
      end
      if (release_req) begin
         for (int i = 0; i < 2; i++)
            if (bank_q[i] == BANK_READING) bank_d[i] = BANK_FREE;
      end
      if (fill_start) bank_d[free_idx] = BANK_FILLING;
      if (fill_done)  bank_d[wr_bank]  = BANK_READY;
      if (bank_d[0] == BANK_READY && bank_d[1] != BANK_READY)
         old_d = 1'b0;
      else if (bank_d[1] == BANK_READY && bank_d[0] != BANK_READY)
         old_d = 1'b1;
      else if (fill_done)
         old_d = ~wr_bank;
   end

   always_comb begin
      err_d = err_q;
      if (host_wr && host.address == REG_ERR)
         err_d = err_inc ? CNT_W'(1) : '0;
      else if (err_inc && err_q != ERR_MAX)
         err_d = err_q + 1'b1;
      irq_en_d = irq_en_q;
      if (host_wr && host.address == REG_IRQEN) irq_en_d = host.writedata[0];
      irq_d = irq_en_q && ready_any && !reading;
   end

   always_comb begin
      readdata_d = readdata_q;
      if (host_rd) begin
         readdata_d = '0;
         case (host.address)
            REG_CTRL: begin
               readdata_d[CTRL_READY_ANY_BIT] = ready_any;
               readdata_d[CTRL_READING_BIT]   = reading;
               readdata_d[CTRL_RD_BANK_BIT]   = rd_bank_q;
            end
            REG_STATUS: begin
               readdata_d[STATUS_BANK1_LSB +: 2] = bank_q[1];
               readdata_d[STATUS_BANK0_LSB +: 2] = bank_q[0];
               readdata_d[STATUS_WR_BANK_BIT]    = wr_bank;
               readdata_d[STATUS_FSM_BIT]        = fsm;
            end
            REG_ERR:   readdata_d = 32'(err_q);
            REG_IRQEN: readdata_d[0] = irq_en_q;
            default:   readdata_d = '0;
         endcase
      end
   end

   assign rd_bank       = rd_bank_q;
   assign host.readdata = readdata_q;
   assign host.irq      = irq_q;

endmodule

// File: tb/tb_ram_bank_handoff_ctrl.sv
// Randomized and directed bench for ram_bank_handoff_ctrl against a queue-based ownership model.
module tb_ram_bank_handoff_ctrl;

   localparam int ADDR_W   = 12;
   localparam int LINE_LEN = 1024;
   localparam int CNT_W    = 3;
   localparam int ERR_SAT  = (1 << CNT_W) - 1;

   logic              clk = 1'b0;
   logic              reset_n = 1'b0;
   logic              acq_sof = 1'b0;
   logic              acq_valid = 1'b0;
   logic              wr_en;
   logic [ADDR_W-1:0] wr_addr;
   logic              wr_bank;
   logic              rd_bank;

   ram_bank_handoff_ctrl_if bus();

   ram_bank_handoff_ctrl #(.ADDR_W(ADDR_W), .LINE_LEN(LINE_LEN), .CNT_W(CNT_W)) dut (
      .clk       (clk),
      .reset_n   (reset_n),
      .acq_sof   (acq_sof),
      .acq_valid (acq_valid),
      .wr_en     (wr_en),
      .wr_addr   (wr_addr),
      .wr_bank   (wr_bank),
      .rd_bank   (rd_bank),
      .host      (bus)
   );

   always #5 clk = ~clk;

   int n_chk = 0;
   int n_bad = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
      end
   endtask

   // Model: bank states 0=FREE 1=FILLING 2=READY 3=READING; READY banks kept oldest-first in a queue.
   int          m_st [2];
   int          m_rq [$];
   bit          m_fill;
   int          m_cur;
   int          m_addr;
   bit          m_pend;
   int          m_err;
   bit          m_irq_en;
   bit          m_rd_bank;
   bit          m_irq;
   logic [31:0] m_rdata;

   task automatic m_reset();
      m_st[0] = 0; m_st[1] = 0;
      m_rq.delete();
      m_fill = 0; m_cur = 0; m_addr = 0; m_pend = 0; m_err = 0;
      m_irq_en = 0; m_rd_bank = 0; m_irq = 0; m_rdata = '0;
   endtask

   function automatic logic [31:0] m_read(input int a, input int st0, input int st1);
      bit rdy, rdg;
      rdy = (st0 == 2) || (st1 == 2);
      rdg = (st0 == 3) || (st1 == 3);
      case (a)
         0: return 32'(rdy) * 4 + 32'(rdg) * 2 + 32'(m_rd_bank);
         1: return 32'(st1) * 64 + 32'(st0) * 16 + 32'(m_cur) * 2 + 32'(m_fill);
         2: return 32'(m_err);
         default: return 32'(m_irq_en);
      endcase
   endfunction

   task automatic m_step(input bit sof, input bit valid, input bit cs, input bit wn,
                         input int a, input logic [31:0] wd);
      int  pre [2];
      bit  rdy, rdg, ws, inc, clr;
      int  b;
      pre[0] = m_st[0]; pre[1] = m_st[1];
      rdy = (m_rq.size() > 0);
      rdg = (pre[0] == 3) || (pre[1] == 3);
      ws  = cs && !wn;
      inc = 0;
      clr = ws && a == 2;
      if (cs && wn) m_rdata = m_read(a, pre[0], pre[1]);
      if (ws && a == 0 && wd[0] && !rdg && rdy) begin
         b = m_rq.pop_front();
         m_st[b] = 3;
         m_rd_bank = b[0];
      end
      if (ws && a == 0 && !wd[0])
         for (int i = 0; i < 2; i++) if (pre[i] == 3) m_st[i] = 0;
      if (m_fill) begin
         if (valid && m_addr == LINE_LEN - 1) begin
            m_st[m_cur] = 2;
            m_rq.push_back(m_cur);
            m_fill = 0;
            m_addr = 0;
            m_pend = sof;
         end else begin
            if (valid) m_addr++;
            if (sof) begin
               inc = 1;
               m_addr = 0;
            end
         end
      end else begin
         if (sof || m_pend) begin
            b = (pre[0] == 0) ? 0 : ((pre[1] == 0) ? 1 : -1);
            if (b >= 0) begin
               m_cur = b; m_st[b] = 1; m_fill = 1; m_addr = 0;
            end else begin
               inc = 1;
            end
         end
         m_pend = 0;
      end
      if (clr) m_err = inc ? 1 : 0;
      else if (inc && m_err < ERR_SAT) m_err++;
      m_irq = m_irq_en && rdy && !rdg;
      if (ws && a == 3) m_irq_en = wd[0];
   endtask

   task automatic cyc(input bit sof, input bit valid, input bit cs, input bit wn,
                      input int a, input logic [31:0] wd);
      @(negedge clk);
      acq_sof = sof; acq_valid = valid;
      bus.chipselect = cs; bus.write_n = wn; bus.address = a[1:0]; bus.writedata = wd;
      #1;
      chk("wr_en",    32'(wr_en),   32'(m_fill && valid));
      chk("wr_addr",  32'(wr_addr), 32'(m_addr));
      chk("wr_bank",  32'(wr_bank), 32'(m_cur));
      chk("rd_bank",  32'(rd_bank), 32'(m_rd_bank));
      chk("irq",      32'(bus.irq), 32'(m_irq));
      chk("readdata", bus.readdata, m_rdata);
      m_step(sof, valid, cs, wn, a, wd);
      @(posedge clk);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) cyc(0, 0, 0, 1, 0, 0);
   endtask

   task automatic host_wr(input int a, input logic [31:0] wd);
      cyc(0, 0, 1, 0, a, wd);
   endtask

   task automatic host_rd_k(input int a, input logic [31:0] exp, input string tag);
      cyc(0, 0, 1, 1, a, 0);
      #1;
      chk(tag, bus.readdata, exp);
   endtask

   task automatic valids(input int n, input int gap_pct);
      int k = 0;
      while (k < n) begin
         if ($urandom_range(99) >= gap_pct) begin
            cyc(0, 1, 0, 1, 0, 0);
            k++;
         end else begin
            cyc(0, 0, 0, 1, 0, 0);
         end
      end
   endtask

   task automatic line(input int gap_pct);
      cyc(1, 0, 0, 1, 0, 0);
      valids(LINE_LEN, gap_pct);
   endtask

   task automatic do_reset();
      @(negedge clk);
      reset_n = 1'b0;
      acq_sof = 0; acq_valid = 0;
      bus.chipselect = 0; bus.write_n = 1; bus.address = 0; bus.writedata = 0;
      #1;
      chk("rst_wr_en",    32'(wr_en),   0);
      chk("rst_wr_addr",  32'(wr_addr), 0);
      chk("rst_wr_bank",  32'(wr_bank), 0);
      chk("rst_rd_bank",  32'(rd_bank), 0);
      chk("rst_irq",      32'(bus.irq), 0);
      chk("rst_readdata", bus.readdata, 0);
      m_reset();
      @(negedge clk);
      reset_n = 1'b1;
   endtask

   initial begin
      bus.chipselect = 0; bus.write_n = 1; bus.address = 0; bus.writedata = 0;
      m_reset();
      repeat (2) @(posedge clk);
      do_reset();
      host_rd_k(1, 32'h0, "status_reset");

      // single line into bank0, irq once enabled
      line(10);
      host_rd_k(1, 32'h20, "status_bank0_ready");
      host_wr(3, 1);
      idle(2);
      chk("irq_after_fill", 32'(bus.irq), 1);

      // oldest-first claims
      do_reset();
      line(10);
      line(10);
      host_wr(0, 1);
      host_rd_k(0, 32'h6, "ctrl_claim_b0");
      host_wr(0, 0);
      host_wr(0, 1);
      host_rd_k(0, 32'h3, "ctrl_claim_b1");
      chk("rd_bank_b1", 32'(rd_bank), 1);

      // overflow accounting
      host_wr(0, 0);
      line(5);
      line(5);
      cyc(1, 0, 0, 1, 0, 0);
      valids(20, 0);
      host_rd_k(2, 32'h1, "err_after_drop");
      host_wr(2, 0);
      host_rd_k(2, 32'h0, "err_cleared");
      for (int i = 0; i < ERR_SAT + 3; i++) cyc(1, 0, 0, 1, 0, 0);
      host_rd_k(2, 32'(ERR_SAT), "err_saturated");
      cyc(1, 0, 1, 0, 2, 0);
      host_rd_k(2, 32'h1, "err_clear_and_inc");

      // truncated line restarts the same bank
      host_wr(0, 1);
      host_wr(0, 0);
      host_wr(0, 1);
      host_wr(0, 0);
      host_wr(2, 0);
      cyc(1, 0, 0, 1, 0, 0);
      valids(500, 10);
      cyc(1, 0, 0, 1, 0, 0);
      #1;
      chk("trunc_addr", 32'(wr_addr), 0);
      chk("trunc_bank", 32'(wr_bank), 0);
      valids(LINE_LEN, 10);
      host_rd_k(2, 32'h1, "err_after_trunc");
      host_rd_k(1, 32'h20, "status_after_trunc");

      // completion coincident with claim
      do_reset();
      cyc(1, 0, 0, 1, 0, 0);
      valids(LINE_LEN - 1, 10);
      cyc(0, 1, 1, 0, 0, 1);
      host_rd_k(0, 32'h4, "ctrl_claim_ignored");
      host_wr(0, 1);
      host_rd_k(0, 32'h2, "ctrl_second_claim");

      // reset mid-line and mid-read
      do_reset();
      cyc(1, 0, 0, 1, 0, 0);
      valids(300, 10);
      do_reset();
      line(10);
      host_wr(0, 1);
      do_reset();
      cyc(1, 0, 0, 1, 0, 0);
      #1;
      chk("post_rst_bank", 32'(wr_bank), 0);
      chk("post_rst_addr", 32'(wr_addr), 0);
      valids(LINE_LEN - 1, 10);
      cyc(1, 1, 0, 1, 0, 0);
      idle(1);
      host_rd_k(1, 32'h63, "status_deferred_sof");

      // randomized traffic
      do_reset();
      for (int c = 0; c < 40000; c++) begin
         bit          sof, v, cs, wn;
         int          a;
         logic [31:0] wd;
         if (c % 15000 == 7499) do_reset();
         sof = ($urandom_range(1199) == 0);
         v   = ($urandom_range(9) != 0);
         cs  = ($urandom_range(29) == 0);
         wn  = $urandom_range(1) != 0;
         a   = $urandom_range(3);
         if (cs && !wn && a == 2 && $urandom_range(3) != 0) a = 0;
         wd  = $urandom();
         cyc(sof, v, cs, wn, a, wd);
      end

      $display("test done: total=%0d bad=%0d", n_chk, n_bad);
      $finish;
   end

endmodule
